// File: rtl/digit_serial_subtractor_pkg.sv
// Shared arithmetic definitions for the digit-serial subtractor: default digit
// width, FSM state encoding and the operand-split legality check.
package digit_serial_subtractor_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // WIDTH must split into whole digits or the last digit would be ragged.
  function automatic bit valid_split(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_serial_subtractor_digit_bla_sub.sv
// Combinational DIGIT-bit borrow-lookahead subtract cell: d = x - y - bi,
// plus group borrow-generate (x < y) and propagate (x == y) for outer lookahead.
module digit_bla_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             g,
  output logic             p
);

  logic [DIGIT-1:0] gen, prop;
  logic [DIGIT:0]   bc;  // borrow into each bit, seeded by bi
  logic [DIGIT:0]   gc;  // same chain seeded by 0: group generate

  assign gen  = ~x & y;
  assign prop = ~(x ^ y);

  always_comb begin
    bc    = '0;
    gc    = '0;
    bc[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      bc[i+1] = gen[i] | (prop[i] & bc[i]);
      gc[i+1] = gen[i] | (prop[i] & gc[i]);
    end
  end

  assign d  = x ^ y ^ bc[DIGIT-1:0];
  assign bo = bc[DIGIT];
  assign g  = gc[DIGIT];
  assign p  = &prop;

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial A - B - bin: one DIGIT-wide slice per RUN cycle, borrow held in a
// register. Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module digit_serial_subtractor
  import digit_serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = DIGIT_W,
  localparam int NDIG  = WIDTH / DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [NDIG-1:0]  bg,
  output logic [NDIG-1:0]  bp
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int            IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  if (!valid_split(WIDTH, DIGIT)) begin : g_bad_split
    $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [NDIG-1:0]  bg_q, bg_d, bp_q, bp_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] cell_x, cell_y, cell_d;
  logic             cell_bo, cell_g, cell_p;

  // Single cell shared across all digits; idx steers the operand slice.
  assign cell_x = a_q[idx_q*DIGIT +: DIGIT];
  assign cell_y = b_q[idx_q*DIGIT +: DIGIT];

  digit_bla_sub #(.DIGIT(DIGIT)) u_cell (
    .x  (cell_x),
    .y  (cell_y),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo),
    .g  (cell_g),
    .p  (cell_p)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bg_d    = bg_q;
    bp_d    = bp_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      RUN: begin
        diff_d[idx_q*DIGIT +: DIGIT] = cell_d;
        br_d        = cell_bo;
        bg_d[idx_q] = cell_g;
        bp_d[idx_q] = cell_p;
        if (idx_q == LAST) begin
          state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
          ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ cell_d[DIGIT-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new start; DONE otherwise falls to IDLE.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          diff_d  = '0;
          bg_d    = '0;
          bp_d    = '0;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bg_q    <= '0;
      bp_q    <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bg_q    <= bg_d;
      bp_q    <= bp_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = br_q;
  assign bg   = bg_q;
  assign bp   = bp_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule
